// File: rtl/booth_r4_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_multiplier
// Description : Sequential radix-4 Booth multiplier, signed/unsigned per
//               transaction, valid/ready handshakes, fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int N_ITER = WIDTH / 2 + 1;
   localparam int CW     = $clog2(N_ITER + 1);
   localparam logic [CW-1:0] C_N_ITER = CW'(N_ITER);
   localparam logic [CW-1:0] C_ONE    = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           r_state;
   logic [CW-1:0]        r_count;
   logic [WIDTH+3:0]     r_a;
   logic [WIDTH+1:0]     r_q;
   logic                 r_qm1;
   logic [WIDTH+1:0]     r_m;
   logic [2*WIDTH-1:0]   r_product;

   logic [WIDTH+3:0]     w_m1;
   logic [WIDTH+3:0]     w_m2;
   logic [WIDTH+3:0]     w_addend;
   logic [WIDTH+3:0]     w_sum;
   logic [2*WIDTH+6:0]   w_shift;
   logic                 w_ext_m;
   logic                 w_ext_q;

   assign w_ext_m = signed_mode & multiplicand[WIDTH-1];
   assign w_ext_q = signed_mode & multiplier[WIDTH-1];

   assign w_m1 = {{2{r_m[WIDTH+1]}}, r_m};
   assign w_m2 = {r_m[WIDTH+1], r_m, 1'b0};

   always_comb begin
      w_addend = '0;
      case ({r_q[1:0], r_qm1})
         3'b001, 3'b010: w_addend = w_m1;
         3'b011:         w_addend = w_m2;
         3'b100:         w_addend = -w_m2;
         3'b101, 3'b110: w_addend = -w_m1;
         default:        w_addend = '0;
      endcase
   end

   assign w_sum   = r_a + w_addend;
   // Arithmetic shift of the whole {A,Q,q_m1} chain retires two multiplier bits.
   assign w_shift = $signed({w_sum, r_q, r_qm1}) >>> 2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_a       <= '0;
         r_q       <= '0;
         r_qm1     <= 1'b0;
         r_m       <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_m     <= {{2{w_ext_m}}, multiplicand};
                  r_q     <= {{2{w_ext_q}}, multiplier};
                  r_a     <= '0;
                  r_qm1   <= 1'b0;
                  r_count <= C_N_ITER;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_a     <= w_shift[2*WIDTH+6:WIDTH+3];
               r_q     <= w_shift[WIDTH+2:1];
               r_qm1   <= w_shift[0];
               r_count <= r_count - C_ONE;
               if (r_count == C_ONE) begin
                  r_product <= w_shift[2*WIDTH:1];
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state == S_CALC);
   assign product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_r4_multiplier
// Description : Self-checking bench: directed vectors, backpressure, reset,
//               random streaming (WIDTH=16) and exhaustive WIDTH=4 sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_r4_multiplier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, signed_mode, out_valid, out_ready, busy;
   logic [15:0] multiplicand, multiplier;
   logic [31:0] product;

   logic        in_valid4, in_ready4, signed_mode4, out_valid4, out_ready4, busy4;
   logic [3:0]  multiplicand4, multiplier4;
   logic [7:0]  product4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   booth_r4_multiplier #(.WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .signed_mode(signed_mode), .multiplicand(multiplicand), .multiplier(multiplier),
      .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
   );

   booth_r4_multiplier #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .signed_mode(signed_mode4), .multiplicand(multiplicand4), .multiplier(multiplier4),
      .out_valid(out_valid4), .out_ready(out_ready4), .product(product4), .busy(busy4)
   );

   typedef struct {
      bit          s;
      logic [15:0] m;
      logic [15:0] q;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      bit          s;
      logic [15:0] m;
      logic [15:0] q;
   } op_t;

   // Golden model: plain integer multiply of the operands as interpreted by the mode.
   function automatic longint ref_mul(input bit s, input longint m, input longint q, input int w);
      longint a, b, mask;
      a = m;
      b = q;
      if (s && a[w-1]) a = a - (64'sd1 <<< w);
      if (s && b[w-1]) b = b - (64'sd1 <<< w);
      mask = (64'sd1 <<< (2 * w)) - 1;
      return (a * b) & mask;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge with in_ready=1; returns product and CALC edge count.
   task automatic run_op16(input bit s, input logic [15:0] m, input logic [15:0] q,
                           output logic [31:0] p, output int lat);
      signed_mode  = s;
      multiplicand = m;
      multiplier   = q;
      in_valid     = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      p = product;
   endtask

   task automatic run_op4(input bit s, input logic [3:0] m, input logic [3:0] q,
                          output logic [7:0] p, output int lat);
      signed_mode4  = s;
      multiplicand4 = m;
      multiplier4   = q;
      in_valid4     = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      p = product4;
   endtask

   vec_t        vecs[$];
   op_t         pend[$];
   op_t         op;
   logic [31:0] p, held;
   logic [7:0]  p4;
   int          lat, sent, got, cyc, last_cyc, bad4;
   bit          bp_ok, quiet;

   initial begin
      vecs.push_back('{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1});
      vecs.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001});
      vecs.push_back('{1'b1, 16'h8000, 16'h8000, 32'h40000000});
      vecs.push_back('{1'b1, 16'h8000, 16'h7FFF, 32'hC0008000});
      vecs.push_back('{1'b0, 16'h8000, 16'h8000, 32'h40000000});
      vecs.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001});
      vecs.push_back('{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001});
      vecs.push_back('{1'b0, 16'h0000, 16'h1234, 32'h00000000});
      vecs.push_back('{1'b1, 16'h0007, 16'hFFFA, 32'hFFFFFFD6});

      rst_n = 1'b0;
      in_valid = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0; out_ready = 1'b1;
      in_valid4 = 1'b0; signed_mode4 = 1'b0; multiplicand4 = '0; multiplier4 = '0; out_ready4 = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_product", product, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < vecs.size(); i++) begin
         run_op16(vecs[i].s, vecs[i].m, vecs[i].q, p, lat);
         check($sformatf("vec%0d_product", i), p, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), lat, 9);
         @(negedge clk);
         check($sformatf("vec%0d_idle", i), {in_ready, out_valid}, 2'b10);
      end

      // Backpressure with input churn while DONE
      out_ready = 1'b0;
      run_op16(1'b1, 16'h1234, 16'hFEDC, p, lat);
      check("bp_product", p, ref_mul(1'b1, 64'h1234, 64'hFEDC, 16));
      held  = product;
      bp_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid     = ~in_valid;
         multiplicand = 16'($urandom);
         multiplier   = 16'($urandom);
         signed_mode  = ~signed_mode;
         @(negedge clk);
         if (!out_valid || in_ready || busy || product !== held) bp_ok = 1'b0;
      end
      check("bp_hold", bp_ok, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release", {in_ready, out_valid}, 2'b10);
      check("bp_product_after", product, held);

      // Reset in the middle of CALC
      signed_mode = 1'b0; multiplicand = 16'd300; multiplier = 16'd500; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("midop_busy", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midop_rst_state", {in_ready, out_valid, busy}, 3'b100);
      check("midop_rst_product", product, 0);
      quiet = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) quiet = 1'b0;
      end
      check("midop_no_result", quiet, 1);
      run_op16(1'b0, 16'd7, 16'd6, p, lat);
      check("post_rst_product", p, 42);
      check("post_rst_latency", lat, 9);
      @(negedge clk);

      // Random back-to-back streaming
      sent = 0; got = 0; cyc = 0; last_cyc = -1;
      while (got < 100 && cyc < 1400) begin
         if (out_valid) begin
            if (pend.size() == 0) begin
               check("stream_unexpected", 1, 0);
            end else begin
               op = pend.pop_front();
               check($sformatf("stream%0d_product", got), product,
                     ref_mul(op.s, {48'b0, op.m}, {48'b0, op.q}, 16));
               if (last_cyc >= 0) check($sformatf("stream%0d_spacing", got), cyc - last_cyc, 11);
            end
            last_cyc = cyc;
            got++;
         end
         if (in_ready && sent < 100) begin
            op.s = 1'($urandom);
            op.m = 16'($urandom);
            op.q = 16'($urandom);
            signed_mode = op.s; multiplicand = op.m; multiplier = op.q;
            in_valid = 1'b1;
            pend.push_back(op);
            sent++;
         end else if (sent >= 100) begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      check("stream_count", got, 100);

      // Exhaustive WIDTH=4 sweep in both modes
      bad4 = 0;
      for (int s = 0; s < 2; s++) begin
         for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
               run_op4(1'(s), 4'(m), 4'(q), p4, lat);
               check($sformatf("w4_s%0d_%0d_%0d", s, m, q), p4, ref_mul(1'(s), m, q, 4));
               if (lat != 3) bad4++;
               @(negedge clk);
            end
         end
      end
      check("w4_latency_errors", bad4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
